shift_rows_stream: RTL and testbench
====================================

SHIFT_ROWS_STREAM -- requirements
Module: shift_rows_stream

Interface
REQ-001 SHALL have parameter NB, default 4, meaning Rijndael state columns; legal values 4, 6, 8.
REQ-002 SHALL have parameter W, default 32*NB, a derived state width in bits that is not overridable.
REQ-003 SHALL have parameter CNT_W, default 16, meaning accepted-block counter width.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  reset; single clock domain, synchronous, active-low.
REQ-006 in_valid  input  1  in_data and in_inv are valid this cycle.
REQ-007 in_ready  output  1  block can accept a beat this cycle.
REQ-008 in_data  input  W  state, row-major: row r at bits [W-1-r*8*NB -: 8*NB]; column 0 is the most significant byte of its row.
REQ-009 in_inv  input  1  0 selects ShiftRows; 1 selects InvShiftRows; sampled per beat.
REQ-010 out_valid  output  1  out_data holds a transformed state.
REQ-011 out_ready  input  1  downstream accepts out_data this cycle.
REQ-012 out_data  output  W  transformed state, same layout as in_data.
REQ-013 blk_count  output  CNT_W  count of beats accepted on the input since reset.

Function
REQ-014 Row r SHALL rotate by offset C(r), where C = {0,1,2,3} for NB=4 and NB=6, and C = {0,1,3,4} for NB=8.
REQ-015 When in_inv=0, each row SHALL rotate left by C(r) bytes, so output column c = input column (c+C(r)) mod NB.
REQ-016 When in_inv=1, each row SHALL rotate right by C(r) bytes, so output column c = input column (c-C(r)) mod NB.
REQ-017 The transform SHALL be applied on acceptance; the stored beat is post-transform and carries no mode bit.
REQ-018 A beat SHALL be accepted only when in_valid && in_ready, and delivered only when out_valid && out_ready.
REQ-019 Storage SHALL be a 2-entry FIFO with occupancy 0, 1 or 2, and in_ready SHALL be (occupancy < 2), a registered value with no combinational path from out_ready.
REQ-020 Latency SHALL be 1 cycle: a beat accepted in cycle N is on out_data with out_valid=1 in cycle N+1 when the FIFO was empty.
REQ-021 Order SHALL be preserved; no beat is dropped or duplicated.
REQ-022 At occupancy 1, a simultaneous push and pop SHALL leave occupancy at 1, and out_data SHALL show the new beat the next cycle.
REQ-023 At occupancy 2 no push occurs, because in_ready=0; a pop SHALL make in_ready=1 the next cycle.
REQ-024 At occupancy 0, a pop SHALL NOT occur because out_valid=0; in_valid with no push is impossible.
REQ-025 While out_valid=1 and out_ready=0, out_data SHALL hold stable.
REQ-026 blk_count SHALL increment by 1 on each accepted beat and wrap from 2^CNT_W-1 to 0.
REQ-027 Read and write pointers SHALL each be 1 bit and toggle on pop and push respectively.

Reset
REQ-028 When rst_n=0 at a clk edge: occupancy=0, both pointers=0, out_valid=0, in_ready=1 on the following cycle, blk_count=0.
REQ-029 Reset mid-stream SHALL discard buffered beats; FIFO data registers need not be cleared.
REQ-030 During reset, in_ready SHALL read 0, so no beat is accepted in a reset cycle.

Structure
REQ-031 Package aes_pkg SHALL hold the shift-offset function shift_offset(nb, row), the legal-NB check, and the byte/row width constants.
REQ-032 A sub-module rijndael_row_rotate SHALL implement the combinational per-row rotation, with parameters NB and offset, and port inv.
REQ-033 An illegal NB SHALL stop elaboration with an $error.

Verification
REQ-034 NB=4, in_inv=0, in_data=128'h000102030405060708090a0b0c0d0e0f -> out_data=128'h00010203050607040a0b08090f0c0d0e, one cycle after acceptance.
REQ-035 NB=4, in_inv=1, same input -> 128'h00010203070405060a0b08090d0e0f0c; chaining the forward then inverse transform -> original state.
REQ-036 NB=8: row 2 bytes 00..07 -> 03040506070001 02 (forward, left 3); row 3 bytes 00..07 -> 0405060700010203.
REQ-037 Hold out_ready=0 and stream 3 beats -> first 2 accepted, in_ready=0, out_data stable; release out_ready -> beats 1,2,3 appear in order.
REQ-038 Random valid/ready for 10k beats with mixed in_inv, checked against a scoreboard -> no loss or reorder, and blk_count=10000 mod 2^16.
REQ-039 Assert rst_n=0 with occupancy 2 -> out_valid=0 and blk_count=0 next cycle; the first beat after reset passes with 1-cycle latency.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared Rijndael constants and helpers for the ShiftRows streaming datapath:
// byte/row geometry, per-row shift offsets and the legal state-width check.
package aes_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned ROWS   = 4;
  localparam int unsigned COL_W  = ROWS * BYTE_W;

  // Occupancy of the 2-entry output FIFO
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  function automatic bit nb_legal(input int unsigned nb);
    return (nb == 4) || (nb == 6) || (nb == 8);
  endfunction

  function automatic int unsigned row_width(input int unsigned nb);
    return nb * BYTE_W;
  endfunction

  // Rijndael row offsets; the wide 256-bit state uses a larger spread on rows 2 and 3
  function automatic int unsigned shift_offset(input int unsigned nb, input int unsigned row);
    int unsigned off;
    off = 0;
    case (row)
      0:       off = 0;
      1:       off = 1;
      2:       off = (nb == 8) ? 3 : 2;
      3:       off = (nb == 8) ? 4 : 3;
      default: off = 0;
    endcase
    return off;
  endfunction

endpackage

// File: rtl/rijndael_row_rotate.sv
// Combinational byte rotation of one state row: left by OFFSET for the forward
// transform, right by OFFSET when inv is set.
module rijndael_row_rotate
  import aes_pkg::*;
#(
  parameter int unsigned NB     = 4,
  parameter int unsigned OFFSET = 0
) (
  input  logic                 inv,
  input  logic [NB*BYTE_W-1:0] data,
  output logic [NB*BYTE_W-1:0] rotated_c
);

  localparam int unsigned ROW_W = NB * BYTE_W;

  if (OFFSET >= NB) begin : g_offset_check
    $error("rijndael_row_rotate: OFFSET %0d out of range for NB %0d", OFFSET, NB);
  end

  // Column 0 is the most significant byte of the row
  for (genvar c = 0; c < NB; c++) begin : g_col
    localparam int unsigned SRC_FWD = (c + OFFSET) % NB;
    localparam int unsigned SRC_INV = (c + NB - OFFSET) % NB;
    localparam int unsigned DST_HI  = ROW_W - 1 - c * BYTE_W;
    localparam int unsigned FWD_HI  = ROW_W - 1 - SRC_FWD * BYTE_W;
    localparam int unsigned INV_HI  = ROW_W - 1 - SRC_INV * BYTE_W;

    assign rotated_c[DST_HI -: BYTE_W] = inv ? data[INV_HI -: BYTE_W]
                                             : data[FWD_HI -: BYTE_W];
  end

endmodule

// File: rtl/shift_rows_stream.sv
// Streaming ShiftRows / InvShiftRows stage: transforms each accepted state and
// buffers it in a 2-entry FIFO with a registered ready and an accept counter.
module shift_rows_stream
  import aes_pkg::*;
#(
  parameter  int unsigned NB    = 4,
  parameter  int unsigned CNT_W = 16,
  localparam int unsigned W     = 32 * NB
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_inv,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [CNT_W-1:0] blk_count
);

  localparam int unsigned ROW_W = row_width(NB);

  if (!nb_legal(NB)) begin : g_nb_check
    $error("shift_rows_stream: NB=%0d is not a legal Rijndael column count (4, 6, 8)", NB);
  end

  logic [W-1:0] shifted_c;

  // One rotator per row; mode is applied before storage so the FIFO holds final data
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    localparam int unsigned HI = W - 1 - r * ROW_W;

    rijndael_row_rotate #(
      .NB     (NB),
      .OFFSET (shift_offset(NB, r))
    ) u_rot (
      .inv       (in_inv),
      .data      (in_data[HI -: ROW_W]),
      .rotated_c (shifted_c[HI -: ROW_W])
    );
  end

  occ_e             occ;
  occ_e             occ_nxt;
  logic             rdy_q;
  logic             rdy_nxt;
  logic             vld_q;
  logic             vld_nxt;
  logic             rd_ptr;
  logic             wr_ptr;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     mem [2];
  logic             push;
  logic             pop;

  // Ready is forced low while reset is asserted so no beat lands in a reset cycle
  assign in_ready  = rdy_q & rst_n;
  assign out_valid = vld_q;
  assign out_data  = mem[rd_ptr];
  assign blk_count = cnt;

  assign push = in_valid & in_ready;
  assign pop  = vld_q & out_ready;

  // Occupancy state register plus pointers and accept counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ    <= OCC_EMPTY;
      rdy_q  <= 1'b1;
      vld_q  <= 1'b0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt    <= '0;
    end else begin
      occ   <= occ_nxt;
      rdy_q <= rdy_nxt;
      vld_q <= vld_nxt;
      if (push) begin
        wr_ptr <= ~wr_ptr;
        cnt    <= cnt + CNT_W'(1);
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
    end
  end

  // Next occupancy; ready/valid are derived from it so both leave the flops directly
  always_comb begin
    occ_nxt = occ;
    rdy_nxt = rdy_q;
    vld_nxt = vld_q;
    case (occ)
      OCC_EMPTY: begin
        if (push) occ_nxt = OCC_ONE;
      end
      OCC_ONE: begin
        if (push && !pop)      occ_nxt = OCC_FULL;
        else if (!push && pop) occ_nxt = OCC_EMPTY;
      end
      OCC_FULL: begin
        if (pop) occ_nxt = OCC_ONE;
      end
      default: occ_nxt = OCC_EMPTY;
    endcase
    rdy_nxt = (occ_nxt != OCC_FULL);
    vld_nxt = (occ_nxt != OCC_EMPTY);
  end

  // Data storage is not reset; stale entries are unreachable once occupancy is cleared
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= shifted_c;
    end
  end

endmodule

// File: tb/tb_shift_rows_stream.sv
// Self-checking bench for shift_rows_stream: directed vector table, NB=8 offsets,
// back-pressure, reset-while-full and a long random handshake run against a queue.
module tb_shift_rows_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         in_valid, in_ready, in_inv, out_valid, out_ready;
  logic [127:0] in_data, out_data;
  logic [15:0]  blk_count;

  logic         in_valid8, in_ready8, in_inv8, out_valid8, out_ready8;
  logic [255:0] in_data8, out_data8;
  logic [15:0]  blk_count8;

  shift_rows_stream #(.NB(4), .CNT_W(16)) u_dut (
    .clk (clk), .rst_n (rst_n),
    .in_valid (in_valid), .in_ready (in_ready), .in_data (in_data), .in_inv (in_inv),
    .out_valid (out_valid), .out_ready (out_ready), .out_data (out_data),
    .blk_count (blk_count)
  );

  shift_rows_stream #(.NB(8), .CNT_W(16)) u_dut8 (
    .clk (clk), .rst_n (rst_n),
    .in_valid (in_valid8), .in_ready (in_ready8), .in_data (in_data8), .in_inv (in_inv8),
    .out_valid (out_valid8), .out_ready (out_ready8), .out_data (out_data8),
    .blk_count (blk_count8)
  );

  int total_cnt = 0;
  int pass_cnt  = 0;

  typedef struct {
    string        name;
    logic         inv;
    logic [127:0] data;
    logic [127:0] exp;
  } vec_t;

  localparam int NVEC = 6;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Independent byte-array reference for the NB=4 transform
  function automatic logic [127:0] model4(input logic inv, input logic [127:0] d);
    logic [127:0] res;
    int src;
    res = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        src = inv ? (c + 4 - r) % 4 : (c + r) % 4;
        res[127 - 8*(4*r + c) -: 8] = d[127 - 8*(4*r + src) -: 8];
      end
    end
    return res;
  endfunction

  logic [127:0] b1, b2, b3, exp_q;
  logic [127:0] q [$];
  int sent, cycles;

  initial begin
    vecs[0] = '{"fwd_ref", 1'b0, 128'h000102030405060708090a0b0c0d0e0f, 128'h00010203050607040a0b08090f0c0d0e};
    vecs[1] = '{"inv_ref", 1'b1, 128'h000102030405060708090a0b0c0d0e0f, 128'h00010203070405060a0b08090d0e0f0c};
    vecs[2] = '{"inv_of_fwd", 1'b1, 128'h00010203050607040a0b08090f0c0d0e, 128'h000102030405060708090a0b0c0d0e0f};
    vecs[3] = '{"fwd_rep", 1'b0, 128'h11223344112233441122334411223344, 128'h11223344223344113344112244112233};
    vecs[4] = '{"inv_rep", 1'b1, 128'h11223344112233441122334411223344, 128'h11223344441122333344112222334411};
    vecs[5] = '{"fwd_zero", 1'b0, 128'h0, 128'h0};

    rst_n = 1'b0;
    in_valid = 1'b0; in_inv = 1'b0; in_data = '0; out_ready = 1'b1;
    in_valid8 = 1'b0; in_inv8 = 1'b0; in_data8 = '0; out_ready8 = 1'b1;
    tick; tick;
    check("rst_ready_low", 256'(in_ready), 256'(0));
    rst_n = 1'b1;
    #1;
    check("rst_ready", 256'(in_ready), 256'(1));
    check("rst_valid", 256'(out_valid), 256'(0));
    check("rst_count", 256'(blk_count), 256'(0));

    // Directed vectors: one-cycle latency from an empty FIFO
    for (int i = 0; i < NVEC; i++) begin
      in_valid = 1'b1; in_inv = vecs[i].inv; in_data = vecs[i].data;
      tick;
      in_valid = 1'b0;
      check({vecs[i].name, "_valid"}, 256'(out_valid), 256'(1));
      check(vecs[i].name, 256'(out_data), 256'(vecs[i].exp));
      tick;
    end
    check("vec_count", 256'(blk_count), 256'(NVEC));

    // NB=8 offsets {0,1,3,4}
    in_valid8 = 1'b1; in_inv8 = 1'b0; in_data8 = {4{64'h0001020304050607}};
    tick;
    in_valid8 = 1'b0;
    check("nb8_fwd", out_data8, {64'h0001020304050607, 64'h0102030405060700,
                                 64'h0304050607000102, 64'h0405060700010203});
    tick;
    in_valid8 = 1'b1; in_inv8 = 1'b1;
    tick;
    in_valid8 = 1'b0;
    check("nb8_inv", out_data8, {64'h0001020304050607, 64'h0700010203040506,
                                 64'h0506070001020304, 64'h0405060700010203});
    tick;

    // Back-pressure: three beats against a stalled sink
    b1 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    b2 = 128'hdeadbeef0badf00dcafebabe12345678;
    b3 = 128'h00112233445566778899aabbccddeeff;
    out_ready = 1'b0;
    in_valid = 1'b1; in_inv = 1'b0; in_data = b1;
    tick;
    check("bp_first", 256'(out_data), 256'(model4(1'b0, b1)));
    in_data = b2;
    tick;
    check("bp_full_ready", 256'(in_ready), 256'(0));
    in_data = b3;
    tick; tick;
    check("bp_hold_ready", 256'(in_ready), 256'(0));
    check("bp_stable", 256'(out_data), 256'(model4(1'b0, b1)));
    check("bp_count", 256'(blk_count), 256'(NVEC + 2));
    out_ready = 1'b1;
    tick;
    check("bp_ready_after_pop", 256'(in_ready), 256'(1));
    check("bp_second", 256'(out_data), 256'(model4(1'b0, b2)));
    tick;
    in_valid = 1'b0;
    check("bp_third", 256'(out_data), 256'(model4(1'b0, b3)));
    check("bp_third_valid", 256'(out_valid), 256'(1));
    tick;
    check("bp_drained", 256'(out_valid), 256'(0));
    check("bp_count_end", 256'(blk_count), 256'(NVEC + 3));

    // Reset while full discards the buffered beats
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = b2;
    tick;
    in_data = b3;
    tick;
    in_valid = 1'b0;
    check("full_before_rst", 256'(in_ready), 256'(0));
    rst_n = 1'b0;
    tick;
    check("mid_rst_valid", 256'(out_valid), 256'(0));
    check("mid_rst_count", 256'(blk_count), 256'(0));
    check("mid_rst_ready", 256'(in_ready), 256'(0));
    rst_n = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; in_inv = 1'b1; in_data = b1;
    #1;
    check("post_rst_ready", 256'(in_ready), 256'(1));
    tick;
    in_valid = 1'b0;
    check("post_rst_valid", 256'(out_valid), 256'(1));
    check("post_rst_data", 256'(out_data), 256'(model4(1'b1, b1)));
    tick;
    check("post_rst_empty", 256'(out_valid), 256'(0));

    // Random handshakes, 10000 beats, from a fresh reset
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    sent = 0; cycles = 0;
    while ((sent < 10000 || q.size() > 0) && cycles < 60000) begin
      in_valid  = (sent < 10000) && ($urandom_range(0, 3) != 0);
      in_inv    = 1'($urandom_range(0, 1));
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_valid && in_ready) begin
        q.push_back(model4(in_inv, in_data));
        sent++;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("rand_spurious", 256'(1), 256'(0));
        end else begin
          exp_q = q.pop_front();
          check("rand_beat", 256'(out_data), 256'(exp_q));
        end
      end
      tick;
      cycles++;
    end
    in_valid = 1'b0;
    check("rand_all_sent", 256'(sent), 256'(10000));
    check("rand_drained", 256'(q.size()), 256'(0));
    check("rand_count", 256'(blk_count), 256'(16'(10000)));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
